// File: rtl/disp_arbiter.sv
// Two-requester display arbiter: grants one requester at a time with a minimum
// hold time, captures the owner's 8-digit value and drives a digit array with
// optional leading-zero suppression. Blank digit code is 4'hA.
module disp_arbiter #(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [31:0]      data_a,
    input  logic             req_b,
    input  logic [31:0]      data_b,
    input  logic             lz_en,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [7:0][3:0]  num,
    output logic [1:0]       fsm_state
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0] BLANK = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Handshake: req_a/req_b are levels sampled every rising edge; a grant
    // appears on gnt_a/gnt_b the cycle after the request is sampled and is
    // held for at least HOLD_CYCLES cycles before ownership can change.

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic            last_b;     // 1 = B was served most recently
    logic [31:0]     cap;
    logic            expired;
    logic [7:0][3:0] disp;
    logic            lead_zero;
    logic [3:0]      nib;

    assign expired   = (hold_cnt == HOLD_MAX);
    assign fsm_state = state;

    // Arbitration FSM with hold counter, fairness pointer and capture register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            hold_cnt <= '0;
            last_b   <= 1'b1;
            cap      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie, the requester not served last wins
                    if (req_a && (!req_b || last_b)) begin
                        state    <= GRANT_A;
                        gnt_a    <= 1'b1;
                        gnt_b    <= 1'b0;
                        hold_cnt <= '0;
                        last_b   <= 1'b0;
                        cap      <= data_a;
                    end else if (req_b) begin
                        state    <= GRANT_B;
                        gnt_a    <= 1'b0;
                        gnt_b    <= 1'b1;
                        hold_cnt <= '0;
                        last_b   <= 1'b1;
                        cap      <= data_b;
                    end
                end
                GRANT_A: begin
                    if (expired && req_b) begin
                        state    <= GRANT_B;
                        gnt_a    <= 1'b0;
                        gnt_b    <= 1'b1;
                        hold_cnt <= '0;
                        last_b   <= 1'b1;
                        cap      <= data_b;
                    end else if (expired && !req_a) begin
                        state    <= IDLE;
                        gnt_a    <= 1'b0;
                        gnt_b    <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        if (!expired) hold_cnt <= hold_cnt + CW'(1);
                        if (req_a) cap <= data_a;
                    end
                end
                GRANT_B: begin
                    if (expired && req_a) begin
                        state    <= GRANT_A;
                        gnt_a    <= 1'b1;
                        gnt_b    <= 1'b0;
                        hold_cnt <= '0;
                        last_b   <= 1'b0;
                        cap      <= data_a;
                    end else if (expired && !req_b) begin
                        state    <= IDLE;
                        gnt_a    <= 1'b0;
                        gnt_b    <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        if (!expired) hold_cnt <= hold_cnt + CW'(1);
                        if (req_b) cap <= data_b;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Digit formatting: blank when idle, optional leading-zero blanking
    // (rightmost digit always shown so a zero value reads as "0")
    always_comb begin
        disp      = '0;
        lead_zero = 1'b1;
        nib       = 4'h0;
        for (int i = 0; i < 8; i++) begin
            nib = cap[4*(7-i) +: 4];
            if (state == IDLE) begin
                disp[i] = BLANK;
            end else if (lz_en && (i < 7) && lead_zero && (nib == 4'h0)) begin
                disp[i] = BLANK;
            end else begin
                disp[i] = nib;
            end
            if (nib != 4'h0) lead_zero = 1'b0;
        end
    end

    // Register the digit array towards the segment driver
    always_ff @(posedge clk) begin
        if (!rst) begin
            num <= {8{BLANK}};
        end else begin
            num <= disp;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD_CYCLES=4.
module tb_disp_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_a, req_b, lz_en;
    logic [31:0]     data_a, data_b;
    logic            gnt_a, gnt_b;
    logic [7:0][3:0] num;
    logic [1:0]      fsm_state;

    int vectors = 0;
    int miscompares = 0;

    disp_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b),
        .lz_en(lz_en),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .num(num), .fsm_state(fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Digits packed leftmost-first so 32'h12345678 means num[0]=1 ... num[7]=8
    function automatic logic [31:0] num_word();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) w[4*(7-i) +: 4] = num[i];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic ea, input logic eb);
        chk({tag, "_gnt_a"}, {31'd0, gnt_a}, {31'd0, ea});
        chk({tag, "_gnt_b"}, {31'd0, gnt_b}, {31'd0, eb});
    endtask

    // Bounded wait for IDLE; an expired budget shows up as a miscompare
    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget && fsm_state != 2'd0; k++) step();
        chk({tag, "_idle"}, {30'd0, fsm_state}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; lz_en = 1'b0;
        data_a = '0; data_b = '0;

        // Reset state
        do_reset();
        chk_grant("reset", 1'b0, 1'b0);
        chk("reset_num", num_word(), 32'hAAAAAAAA);
        chk("reset_state", {30'd0, fsm_state}, 32'd0);

        // Single request from A: grant next cycle, digits a cycle later
        req_a = 1'b1; data_a = 32'h12345678;
        step();
        chk_grant("a_first", 1'b1, 1'b0);
        step();
        chk_grant("a_second", 1'b1, 1'b0);
        chk("a_num", num_word(), 32'h12345678);
        req_a = 1'b0;
        wait_idle("a_release", 10);
        step();
        chk("a_idle_num", num_word(), 32'hAAAAAAAA);

        // Both requesting after reset: A, then B after 4 cycles, then A again
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 32'h11111111; data_b = 32'h22222222;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k >= 4 && k < 8) chk_grant($sformatf("tie_%0d", k), 1'b0, 1'b1);
            else                 chk_grant($sformatf("tie_%0d", k), 1'b1, 1'b0);
        end
        req_a = 1'b0; req_b = 1'b0;
        wait_idle("tie_release", 10);
        step();

        // One-cycle request from B: held exactly 4 cycles, then IDLE
        req_b = 1'b1; data_b = 32'h0000ABCD;
        step();
        req_b = 1'b0;
        chk_grant("b_pulse_0", 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk_grant($sformatf("b_pulse_%0d", k), 1'b0, 1'b1);
            if (k == 1) chk("b_pulse_num", num_word(), 32'h0000ABCD);
        end
        step();
        chk_grant("b_pulse_end", 1'b0, 1'b0);
        chk("b_pulse_state", {30'd0, fsm_state}, 32'd0);
        step();
        chk("b_pulse_blank", num_word(), 32'hAAAAAAAA);

        // Leading-zero suppression
        lz_en = 1'b1; req_a = 1'b1; data_a = 32'h00000000;
        step();
        step();
        chk("lz_zero", num_word(), 32'hAAAAAAA0);
        data_a = 32'h00120030;
        step();
        step();
        chk("lz_mixed", num_word(), 32'hAA120030);
        lz_en = 1'b0;
        step();
        chk("lz_off", num_word(), 32'h00120030);
        data_a = 32'h00F0E000;
        step();
        step();
        chk("lz_off_hex", num_word(), 32'h00F0E000);
        // Hold long expired, only owner requesting: stays granted
        chk_grant("hold_stay", 1'b1, 1'b0);
        req_a = 1'b0;
        wait_idle("lz_release", 10);
        step();

        // Live update while requesting, freeze after request drops
        req_a = 1'b1; data_a = 32'h00000001;
        step();
        data_a = 32'h00000002;
        step();
        chk("live_1", num_word(), 32'h00000001);
        step();
        chk("live_2", num_word(), 32'h00000002);
        req_a = 1'b0; data_a = 32'h00000009;
        step();
        chk("frozen", num_word(), 32'h00000002);
        chk_grant("frozen_gnt", 1'b1, 1'b0);
        wait_idle("frozen_release", 10);
        step();

        // Reset during GRANT_B, then a tie goes to A
        req_b = 1'b1; data_b = 32'h87654321;
        step();
        step();
        chk_grant("pre_rst", 1'b0, 1'b1);
        rst = 1'b0;
        step();
        chk_grant("mid_rst", 1'b0, 1'b0);
        chk("mid_rst_num", num_word(), 32'hAAAAAAAA);
        rst = 1'b1; req_a = 1'b1; data_a = 32'h0000000C;
        step();
        chk_grant("post_rst", 1'b1, 1'b0);
        step();
        chk("post_rst_num", num_word(), 32'h0000000C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Mutual exclusion on every cycle
    always @(negedge clk) begin
        if (rst === 1'b1 && gnt_a === 1'b1 && gnt_b === 1'b1) begin
            vectors++;
            miscompares++;
            $error("FAIL both_grants observed=11 expected=not 11");
        end
    end

endmodule
